// File: rtl/register_access_pkg.sv
// Shared encodings for the register-access stage: operand modes, writeback
// sizes, register numbering and the captured decode payload layout.
package register_access_pkg;

    localparam logic [2:0] OP_MODRM_REG = 3'd4;
    localparam logic [2:0] OP_MODRM_RM  = 3'd5;

    typedef enum logic [2:0] {
        SIZE_8  = 3'd0,
        SIZE_16 = 3'd1,
        SIZE_32 = 3'd2
    } wb_size_e;

    localparam logic [2:0] GPR_EAX = 3'd0;
    localparam logic [2:0] GPR_ECX = 3'd1;
    localparam logic [2:0] GPR_EDX = 3'd2;
    localparam logic [2:0] GPR_EBX = 3'd3;
    localparam logic [2:0] GPR_ESP = 3'd4;
    localparam logic [2:0] GPR_EBP = 3'd5;
    localparam logic [2:0] GPR_ESI = 3'd6;
    localparam logic [2:0] GPR_EDI = 3'd7;

    localparam logic [2:0] SEG_ES = 3'd0;
    localparam logic [2:0] SEG_CS = 3'd1;
    localparam logic [2:0] SEG_SS = 3'd2;
    localparam logic [2:0] SEG_DS = 3'd3;
    localparam logic [2:0] SEG_FS = 3'd4;
    localparam logic [2:0] SEG_GS = 3'd5;

    localparam int NUM_GPR = 8;
    localparam int NUM_SEG = 6;
    localparam int NUM_MMX = 8;

    typedef struct packed {
        logic [2:0]  size;
        logic        set_d_flag;
        logic        clear_d_flag;
        logic [2:0]  op0;
        logic [2:0]  op1;
        logic [2:0]  op0_reg;
        logic [2:0]  op1_reg;
        logic [7:0]  modrm;
        logic [7:0]  sib;
        logic [47:0] imm;
        logic [31:0] disp;
        logic [3:0]  alu_op;
        logic [2:0]  flag_0;
        logic [2:0]  flag_1;
        logic [1:0]  stack_op;
        logic [2:0]  seg_override;
        logic        seg_override_valid;
        logic [31:0] pc;
        logic        branch_taken;
    } payload_t;

    // Operands addressed through ModRM take their register number from it.
    function automatic logic [2:0] resolve_op_reg(input logic [2:0] mode,
                                                  input logic [7:0] modrm,
                                                  input logic [2:0] op_reg);
        logic [2:0] result;
        result = op_reg;
        if (mode == OP_MODRM_REG) begin
            result = modrm[5:3];
        end else if (mode == OP_MODRM_RM) begin
            result = modrm[2:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/register_access_top_register_file.sv
// Architected GPR, segment and MMX state with independent writeback ports.
// Outputs come straight from the state registers (no write forwarding).
module register_file
    import register_access_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic [2:0]                 wb_reg_number,
    input  logic                       wb_reg_en,
    input  logic [2:0]                 wb_reg_size,
    input  logic [31:0]                wb_reg_data,
    input  logic [2:0]                 wb_seg_number,
    input  logic                       wb_seg_en,
    input  logic [15:0]                wb_seg_data,
    input  logic [2:0]                 wb_mmx_number,
    input  logic                       wb_mmx_en,
    input  logic [63:0]                wb_mmx_data,
    output logic [NUM_GPR-1:0][31:0]   gpr,
    output logic [NUM_SEG-1:0][15:0]   seg,
    output logic [NUM_MMX-1:0][63:0]   mmx
);

    genvar gi;

    generate
        for (gi = 0; gi < NUM_GPR; gi++) begin : g_gpr
            localparam logic [2:0] IDX     = 3'(gi);
            localparam logic [2:0] HI_IDX  = 3'(gi + 4);
            // Byte numbers 4-7 alias bits [15:8] of eax/ecx/edx/ebx.
            localparam bit HAS_HIGH_BYTE   = (gi < 4);
            logic [31:0] value_reg;
            logic [31:0] value_next;

            always_comb begin
                value_next = value_reg;
                if (wb_reg_en) begin
                    case (wb_reg_size)
                        SIZE_8: begin
                            if (HAS_HIGH_BYTE && wb_reg_number == IDX) begin
                                value_next[7:0] = wb_reg_data[7:0];
                            end
                            if (HAS_HIGH_BYTE && wb_reg_number == HI_IDX) begin
                                value_next[15:8] = wb_reg_data[7:0];
                            end
                        end
                        SIZE_16: begin
                            if (wb_reg_number == IDX) begin
                                value_next[15:0] = wb_reg_data[15:0];
                            end
                        end
                        SIZE_32: begin
                            if (wb_reg_number == IDX) begin
                                value_next = wb_reg_data;
                            end
                        end
                        default: value_next = value_reg;
                    endcase
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    value_reg <= '0;
                end else begin
                    value_reg <= value_next;
                end
            end

            assign gpr[gi] = value_reg;
        end

        for (gi = 0; gi < NUM_SEG; gi++) begin : g_seg
            localparam logic [2:0] IDX = 3'(gi);
            logic [15:0] value_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    value_reg <= '0;
                end else if (wb_seg_en && wb_seg_number == IDX) begin
                    value_reg <= wb_seg_data;
                end
            end

            assign seg[gi] = value_reg;
        end

        for (gi = 0; gi < NUM_MMX; gi++) begin : g_mmx
            localparam logic [2:0] IDX = 3'(gi);
            logic [63:0] value_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    value_reg <= '0;
                end else if (wb_mmx_en && wb_mmx_number == IDX) begin
                    value_reg <= wb_mmx_data;
                end
            end

            assign mmx[gi] = value_reg;
        end
    endgenerate

endmodule

// File: rtl/register_access_top.sv
// Register-access stage: one-entry pipeline register carrying the decoded
// instruction, with ModRM operand-number resolution, plus the register file.
module register_access_top
    import register_access_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        d_valid,
    output logic        d_ready,
    input  logic [2:0]  d_size,
    input  logic        d_set_d_flag,
    input  logic        d_clear_d_flag,
    input  logic [2:0]  d_op0,
    input  logic [2:0]  d_op1,
    input  logic [2:0]  d_op0_reg,
    input  logic [2:0]  d_op1_reg,
    input  logic [7:0]  d_modrm,
    input  logic [7:0]  d_sib,
    input  logic [47:0] d_imm,
    input  logic [31:0] d_disp,
    input  logic [3:0]  d_alu_op,
    input  logic [2:0]  d_flag_0,
    input  logic [2:0]  d_flag_1,
    input  logic [1:0]  d_stack_op,
    input  logic [2:0]  d_seg_override,
    input  logic        d_seg_override_valid,
    input  logic [31:0] d_pc,
    input  logic        d_branch_taken,
    output logic        r_valid,
    input  logic        r_ready,
    output logic [2:0]  r_size,
    output logic        r_set_d_flag,
    output logic        r_clear_d_flag,
    output logic [2:0]  r_op0,
    output logic [2:0]  r_op1,
    output logic [2:0]  r_op0_reg,
    output logic [2:0]  r_op1_reg,
    output logic [7:0]  r_modrm,
    output logic [7:0]  r_sib,
    output logic [47:0] r_imm,
    output logic [31:0] r_disp,
    output logic [3:0]  r_alu_op,
    output logic [2:0]  r_flag_0,
    output logic [2:0]  r_flag_1,
    output logic [1:0]  r_stack_op,
    output logic [2:0]  r_seg_override,
    output logic        r_seg_override_valid,
    output logic [31:0] r_pc,
    output logic        r_branch_taken,
    output logic [31:0] r_eax,
    output logic [31:0] r_ecx,
    output logic [31:0] r_edx,
    output logic [31:0] r_ebx,
    output logic [31:0] r_esp,
    output logic [31:0] r_ebp,
    output logic [31:0] r_esi,
    output logic [31:0] r_edi,
    output logic [15:0] r_cs,
    output logic [15:0] r_ds,
    output logic [15:0] r_es,
    output logic [15:0] r_fs,
    output logic [15:0] r_gs,
    output logic [15:0] r_ss,
    output logic [63:0] r_mm0,
    output logic [63:0] r_mm1,
    output logic [63:0] r_mm2,
    output logic [63:0] r_mm3,
    output logic [63:0] r_mm4,
    output logic [63:0] r_mm5,
    output logic [63:0] r_mm6,
    output logic [63:0] r_mm7,
    input  logic [2:0]  wb_reg_number,
    input  logic        wb_reg_en,
    input  logic [2:0]  wb_reg_size,
    input  logic [31:0] wb_reg_data,
    input  logic [2:0]  wb_seg_number,
    input  logic        wb_seg_en,
    input  logic [15:0] wb_seg_data,
    input  logic [2:0]  wb_mmx_number,
    input  logic        wb_mmx_en,
    input  logic [63:0] wb_mmx_data
);

    logic     r_valid_reg;
    payload_t payload_reg;
    payload_t payload_next;

    logic [NUM_GPR-1:0][31:0] gpr;
    logic [NUM_SEG-1:0][15:0] seg;
    logic [NUM_MMX-1:0][63:0] mmx;

    assign d_ready = !r_valid_reg || r_ready;

    always_comb begin
        payload_next                    = '0;
        payload_next.size               = d_size;
        payload_next.set_d_flag         = d_set_d_flag;
        payload_next.clear_d_flag       = d_clear_d_flag;
        payload_next.op0                = d_op0;
        payload_next.op1                = d_op1;
        payload_next.op0_reg            = resolve_op_reg(d_op0, d_modrm, d_op0_reg);
        payload_next.op1_reg            = resolve_op_reg(d_op1, d_modrm, d_op1_reg);
        payload_next.modrm              = d_modrm;
        payload_next.sib                = d_sib;
        payload_next.imm                = d_imm;
        payload_next.disp               = d_disp;
        payload_next.alu_op             = d_alu_op;
        payload_next.flag_0             = d_flag_0;
        payload_next.flag_1             = d_flag_1;
        payload_next.stack_op           = d_stack_op;
        payload_next.seg_override       = d_seg_override;
        payload_next.seg_override_valid = d_seg_override_valid;
        payload_next.pc                 = d_pc;
        payload_next.branch_taken       = d_branch_taken;
    end

    // Flush wins over a load; the payload only changes when a load is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid_reg <= 1'b0;
            payload_reg <= '0;
        end else if (flush) begin
            r_valid_reg <= 1'b0;
        end else if (d_valid && d_ready) begin
            r_valid_reg <= 1'b1;
            payload_reg <= payload_next;
        end else if (r_ready) begin
            r_valid_reg <= 1'b0;
        end
    end

    assign r_valid              = r_valid_reg;
    assign r_size               = payload_reg.size;
    assign r_set_d_flag         = payload_reg.set_d_flag;
    assign r_clear_d_flag       = payload_reg.clear_d_flag;
    assign r_op0                = payload_reg.op0;
    assign r_op1                = payload_reg.op1;
    assign r_op0_reg            = payload_reg.op0_reg;
    assign r_op1_reg            = payload_reg.op1_reg;
    assign r_modrm              = payload_reg.modrm;
    assign r_sib                = payload_reg.sib;
    assign r_imm                = payload_reg.imm;
    assign r_disp               = payload_reg.disp;
    assign r_alu_op             = payload_reg.alu_op;
    assign r_flag_0             = payload_reg.flag_0;
    assign r_flag_1             = payload_reg.flag_1;
    assign r_stack_op           = payload_reg.stack_op;
    assign r_seg_override       = payload_reg.seg_override;
    assign r_seg_override_valid = payload_reg.seg_override_valid;
    assign r_pc                 = payload_reg.pc;
    assign r_branch_taken       = payload_reg.branch_taken;

    register_file u_register_file (
        .clk           (clk),
        .reset         (reset),
        .wb_reg_number (wb_reg_number),
        .wb_reg_en     (wb_reg_en),
        .wb_reg_size   (wb_reg_size),
        .wb_reg_data   (wb_reg_data),
        .wb_seg_number (wb_seg_number),
        .wb_seg_en     (wb_seg_en),
        .wb_seg_data   (wb_seg_data),
        .wb_mmx_number (wb_mmx_number),
        .wb_mmx_en     (wb_mmx_en),
        .wb_mmx_data   (wb_mmx_data),
        .gpr           (gpr),
        .seg           (seg),
        .mmx           (mmx)
    );

    assign r_eax = gpr[GPR_EAX];
    assign r_ecx = gpr[GPR_ECX];
    assign r_edx = gpr[GPR_EDX];
    assign r_ebx = gpr[GPR_EBX];
    assign r_esp = gpr[GPR_ESP];
    assign r_ebp = gpr[GPR_EBP];
    assign r_esi = gpr[GPR_ESI];
    assign r_edi = gpr[GPR_EDI];

    assign r_es = seg[SEG_ES];
    assign r_cs = seg[SEG_CS];
    assign r_ss = seg[SEG_SS];
    assign r_ds = seg[SEG_DS];
    assign r_fs = seg[SEG_FS];
    assign r_gs = seg[SEG_GS];

    assign r_mm0 = mmx[0];
    assign r_mm1 = mmx[1];
    assign r_mm2 = mmx[2];
    assign r_mm3 = mmx[3];
    assign r_mm4 = mmx[4];
    assign r_mm5 = mmx[5];
    assign r_mm6 = mmx[6];
    assign r_mm7 = mmx[7];

endmodule

// File: tb/tb_register_access_top.sv
// Randomized bench for register_access_top against a behavioural model of
// the pipeline register and the architected register state.
module tb_register_access_top;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        d_valid, d_ready;
    logic [2:0]  d_size;
    logic        d_set_d_flag, d_clear_d_flag;
    logic [2:0]  d_op0, d_op1, d_op0_reg, d_op1_reg;
    logic [7:0]  d_modrm, d_sib;
    logic [47:0] d_imm;
    logic [31:0] d_disp;
    logic [3:0]  d_alu_op;
    logic [2:0]  d_flag_0, d_flag_1;
    logic [1:0]  d_stack_op;
    logic [2:0]  d_seg_override;
    logic        d_seg_override_valid;
    logic [31:0] d_pc;
    logic        d_branch_taken;
    logic        r_valid, r_ready;
    logic [2:0]  r_size;
    logic        r_set_d_flag, r_clear_d_flag;
    logic [2:0]  r_op0, r_op1, r_op0_reg, r_op1_reg;
    logic [7:0]  r_modrm, r_sib;
    logic [47:0] r_imm;
    logic [31:0] r_disp;
    logic [3:0]  r_alu_op;
    logic [2:0]  r_flag_0, r_flag_1;
    logic [1:0]  r_stack_op;
    logic [2:0]  r_seg_override;
    logic        r_seg_override_valid;
    logic [31:0] r_pc;
    logic        r_branch_taken;
    logic [31:0] r_eax, r_ecx, r_edx, r_ebx, r_esp, r_ebp, r_esi, r_edi;
    logic [15:0] r_cs, r_ds, r_es, r_fs, r_gs, r_ss;
    logic [63:0] r_mm0, r_mm1, r_mm2, r_mm3, r_mm4, r_mm5, r_mm6, r_mm7;
    logic [2:0]  wb_reg_number, wb_reg_size, wb_seg_number, wb_mmx_number;
    logic        wb_reg_en, wb_seg_en, wb_mmx_en;
    logic [31:0] wb_reg_data;
    logic [15:0] wb_seg_data;
    logic [63:0] wb_mmx_data;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state
    logic         m_valid;
    logic [161:0] m_payload;
    logic [31:0]  m_gpr [8];
    logic [15:0]  m_seg [8];
    logic [63:0]  m_mmx [8];

    always #5 clk = ~clk;

    register_access_top dut (
        .clk(clk), .reset(reset), .flush(flush),
        .d_valid(d_valid), .d_ready(d_ready),
        .d_size(d_size), .d_set_d_flag(d_set_d_flag), .d_clear_d_flag(d_clear_d_flag),
        .d_op0(d_op0), .d_op1(d_op1), .d_op0_reg(d_op0_reg), .d_op1_reg(d_op1_reg),
        .d_modrm(d_modrm), .d_sib(d_sib), .d_imm(d_imm), .d_disp(d_disp),
        .d_alu_op(d_alu_op), .d_flag_0(d_flag_0), .d_flag_1(d_flag_1),
        .d_stack_op(d_stack_op), .d_seg_override(d_seg_override),
        .d_seg_override_valid(d_seg_override_valid), .d_pc(d_pc),
        .d_branch_taken(d_branch_taken),
        .r_valid(r_valid), .r_ready(r_ready),
        .r_size(r_size), .r_set_d_flag(r_set_d_flag), .r_clear_d_flag(r_clear_d_flag),
        .r_op0(r_op0), .r_op1(r_op1), .r_op0_reg(r_op0_reg), .r_op1_reg(r_op1_reg),
        .r_modrm(r_modrm), .r_sib(r_sib), .r_imm(r_imm), .r_disp(r_disp),
        .r_alu_op(r_alu_op), .r_flag_0(r_flag_0), .r_flag_1(r_flag_1),
        .r_stack_op(r_stack_op), .r_seg_override(r_seg_override),
        .r_seg_override_valid(r_seg_override_valid), .r_pc(r_pc),
        .r_branch_taken(r_branch_taken),
        .r_eax(r_eax), .r_ecx(r_ecx), .r_edx(r_edx), .r_ebx(r_ebx),
        .r_esp(r_esp), .r_ebp(r_ebp), .r_esi(r_esi), .r_edi(r_edi),
        .r_cs(r_cs), .r_ds(r_ds), .r_es(r_es), .r_fs(r_fs), .r_gs(r_gs), .r_ss(r_ss),
        .r_mm0(r_mm0), .r_mm1(r_mm1), .r_mm2(r_mm2), .r_mm3(r_mm3),
        .r_mm4(r_mm4), .r_mm5(r_mm5), .r_mm6(r_mm6), .r_mm7(r_mm7),
        .wb_reg_number(wb_reg_number), .wb_reg_en(wb_reg_en),
        .wb_reg_size(wb_reg_size), .wb_reg_data(wb_reg_data),
        .wb_seg_number(wb_seg_number), .wb_seg_en(wb_seg_en), .wb_seg_data(wb_seg_data),
        .wb_mmx_number(wb_mmx_number), .wb_mmx_en(wb_mmx_en), .wb_mmx_data(wb_mmx_data)
    );

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [2:0] model_op_reg(input logic [2:0] mode, input logic [2:0] op_reg);
        if (mode == 3'd4) return 3'((d_modrm >> 3) & 8'd7);
        if (mode == 3'd5) return 3'(d_modrm & 8'd7);
        return op_reg;
    endfunction

    function automatic logic [161:0] model_capture();
        return {d_size, d_set_d_flag, d_clear_d_flag, d_op0, d_op1,
                model_op_reg(d_op0, d_op0_reg), model_op_reg(d_op1, d_op1_reg),
                d_modrm, d_sib, d_imm, d_disp, d_alu_op, d_flag_0, d_flag_1,
                d_stack_op, d_seg_override, d_seg_override_valid, d_pc, d_branch_taken};
    endfunction

    function automatic logic [161:0] observed_payload();
        return {r_size, r_set_d_flag, r_clear_d_flag, r_op0, r_op1, r_op0_reg, r_op1_reg,
                r_modrm, r_sib, r_imm, r_disp, r_alu_op, r_flag_0, r_flag_1,
                r_stack_op, r_seg_override, r_seg_override_valid, r_pc, r_branch_taken};
    endfunction

    task automatic model_reset();
        m_valid   = 1'b0;
        m_payload = '0;
        for (int i = 0; i < 8; i++) begin
            m_gpr[i] = '0;
            m_seg[i] = '0;
            m_mmx[i] = '0;
        end
    endtask

    task automatic check_all_state(input string tag);
        logic [31:0] g [8];
        logic [15:0] s [6];
        logic [63:0] m [8];
        g = '{r_eax, r_ecx, r_edx, r_ebx, r_esp, r_ebp, r_esi, r_edi};
        s = '{r_es, r_cs, r_ss, r_ds, r_fs, r_gs};
        m = '{r_mm0, r_mm1, r_mm2, r_mm3, r_mm4, r_mm5, r_mm6, r_mm7};
        check({tag, " r_valid"}, 192'(r_valid), 192'(m_valid));
        check({tag, " payload"}, 192'(observed_payload()), 192'(m_payload));
        for (int i = 0; i < 8; i++) check($sformatf("%s gpr%0d", tag, i), 192'(g[i]), 192'(m_gpr[i]));
        for (int i = 0; i < 6; i++) check($sformatf("%s seg%0d", tag, i), 192'(s[i]), 192'(m_seg[i]));
        for (int i = 0; i < 8; i++) check($sformatf("%s mm%0d", tag, i), 192'(m[i]), 192'(m_mmx[i]));
    endtask

    task automatic clear_inputs();
        flush = 0; d_valid = 0; r_ready = 0;
        {d_size, d_set_d_flag, d_clear_d_flag, d_op0, d_op1, d_op0_reg, d_op1_reg,
         d_modrm, d_sib, d_imm, d_disp, d_alu_op, d_flag_0, d_flag_1,
         d_stack_op, d_seg_override, d_seg_override_valid, d_pc, d_branch_taken} = '0;
        wb_reg_en = 0; wb_seg_en = 0; wb_mmx_en = 0;
        wb_reg_number = 0; wb_reg_size = 0; wb_reg_data = 0;
        wb_seg_number = 0; wb_seg_data = 0; wb_mmx_number = 0; wb_mmx_data = 0;
    endtask

    task automatic randomize_inputs();
        flush = ($urandom_range(7) == 0);
        d_valid = 1'($urandom); r_ready = ($urandom_range(3) != 0);
        {d_size, d_set_d_flag, d_clear_d_flag, d_op0, d_op1, d_op0_reg, d_op1_reg} = 18'($urandom);
        {d_modrm, d_sib, d_alu_op, d_flag_0, d_flag_1, d_stack_op} = 30'($urandom);
        d_imm = {16'($urandom), 32'($urandom)};
        d_disp = $urandom; d_pc = $urandom;
        {d_seg_override, d_seg_override_valid, d_branch_taken} = 5'($urandom);
        {wb_reg_en, wb_seg_en, wb_mmx_en} = 3'($urandom);
        {wb_reg_number, wb_reg_size, wb_seg_number, wb_mmx_number} = 12'($urandom);
        wb_reg_data = $urandom; wb_seg_data = 16'($urandom);
        wb_mmx_data = {32'($urandom), 32'($urandom)};
    endtask

    // Called just after a falling edge with inputs driven; advances one cycle.
    task automatic step(input string tag);
        #1;
        check({tag, " d_ready"}, 192'(d_ready), 192'(!m_valid || r_ready));
        if (flush) m_valid = 1'b0;
        else if (d_valid && (!m_valid || r_ready)) begin
            m_valid = 1'b1;
            m_payload = model_capture();
        end else if (r_ready) m_valid = 1'b0;
        if (wb_reg_en) begin
            case (wb_reg_size)
                3'd0: if (wb_reg_number < 4) m_gpr[wb_reg_number][7:0] = wb_reg_data[7:0];
                      else m_gpr[wb_reg_number - 4][15:8] = wb_reg_data[7:0];
                3'd1: m_gpr[wb_reg_number][15:0] = wb_reg_data[15:0];
                3'd2: m_gpr[wb_reg_number] = wb_reg_data;
                default: ;
            endcase
        end
        if (wb_seg_en && wb_seg_number < 6) m_seg[wb_seg_number] = wb_seg_data;
        if (wb_mmx_en) m_mmx[wb_mmx_number] = wb_mmx_data;
        @(posedge clk); #1;
        check_all_state(tag);
        @(negedge clk);
    endtask

    task automatic apply_reset_mid_cycle(input string tag);
        #2 reset = 0;
        #1;
        model_reset();
        check_all_state(tag);
        check({tag, " d_ready"}, 192'(d_ready), 192'(1));
        @(negedge clk);
        check({tag, " held"}, 192'(r_valid), 192'(0));
        reset = 1;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        reset = 0;
        d_valid = 1; r_ready = 0;
        repeat (2) @(negedge clk);
        check_all_state("reset");
        check("reset d_ready", 192'(d_ready), 192'(1));
        reset = 1;

        // Plain operand modes pass op regs through
        d_valid = 1; r_ready = 1; d_op0 = 1; d_op1 = 1; d_op0_reg = 2; d_op1_reg = 3;
        step("plain");
        check("plain op0_reg", 192'(r_op0_reg), 192'(2));
        check("plain op1_reg", 192'(r_op1_reg), 192'(3));
        check("plain valid", 192'(r_valid), 192'(1));

        d_op0 = 4; d_op1 = 5; d_modrm = 8'hC7;
        step("modrm_c7");
        check("c7 op0_reg", 192'(r_op0_reg), 192'(0));
        check("c7 op1_reg", 192'(r_op1_reg), 192'(7));
        d_modrm = 8'hFF;
        step("modrm_ff");
        check("ff op0_reg", 192'(r_op0_reg), 192'(7));
        check("ff op1_reg", 192'(r_op1_reg), 192'(7));

        // GPR write then high-byte alias of eax
        d_valid = 0;
        wb_reg_en = 1; wb_reg_number = 0; wb_reg_size = 2; wb_reg_data = 32'h12345678;
        step("wb_eax32");
        wb_reg_number = 4; wb_reg_size = 0; wb_reg_data = 32'h000000AB;
        step("wb_ah");
        check("eax merge", 192'(r_eax), 192'(32'h1234AB78));
        wb_reg_en = 0;

        // Simultaneous segment and MMX writes
        wb_seg_en = 1; wb_seg_number = 3; wb_seg_data = 16'h0010;
        wb_mmx_en = 1; wb_mmx_number = 7; wb_mmx_data = 64'hDEADBEEF_00000001;
        step("wb_seg_mmx");
        check("ds", 192'(r_ds), 192'(16'h0010));
        check("mm7", 192'(r_mm7), 192'(64'hDEADBEEF_00000001));
        wb_seg_en = 0; wb_mmx_en = 0;

        // Stall holds outputs, then flush empties the stage
        d_valid = 1; r_ready = 0; d_pc = 32'hCAFE0001;
        step("load_stall");
        d_pc = 32'hCAFE0002;
        step("stall_hold");
        check("stall d_ready", 192'(d_ready), 192'(0));
        check("stall pc", 192'(r_pc), 192'(32'hCAFE0001));
        flush = 1;
        step("flush");
        check("flush valid", 192'(r_valid), 192'(0));
        flush = 0;

        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            step($sformatf("rand%0d", i));
            if (i == 200) apply_reset_mid_cycle("midreset");
        end

        // Reset while a loaded instruction is stalled
        clear_inputs();
        d_valid = 1; d_pc = 32'h0BAD0BAD;
        step("preload");
        apply_reset_mid_cycle("stall_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
